// File: rtl/llc_set_fetch_pkg.sv
// rtl/llc_set_fetch_pkg.sv - shared types and constants for the LLC set fetch stage
package llc_set_fetch_pkg;

    localparam int LLC_WAYS       = 16;
    localparam int LLC_WAY_BITS   = $clog2(LLC_WAYS);
    localparam int LLC_SET_BITS   = 9;
    localparam int LLC_TAG_BITS   = 15;
    localparam int LLC_STATE_BITS = 3;
    localparam int LLC_OWNER_BITS = 4;
    localparam int LLC_LINE_BITS  = 128;

    typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
    typedef logic [LLC_STATE_BITS-1:0] llc_state_t;
    typedef logic [LLC_OWNER_BITS-1:0] owner_t;
    typedef logic [LLC_LINE_BITS-1:0]  line_t;
    typedef logic [LLC_WAY_BITS-1:0]   llc_way_t;
    typedef logic [LLC_SET_BITS-1:0]   llc_set_t;

    // Invalid coherence state
    localparam llc_state_t LLC_I = '0;

    // Lookup stage operating mode driven by this stage
    localparam logic LLC_LOOKUP = 1'b1;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_READ,
        FETCH_CAPTURE,
        FETCH_HOLD
    } fetch_state_t;

endpackage

// File: rtl/llc_way_buf.sv
// rtl/llc_way_buf.sv - one way of the set buffer: SRAM capture with write-forward override
module llc_way_buf
    import llc_set_fetch_pkg::*;
#(
    parameter int TAG_BITS   = LLC_TAG_BITS,
    parameter int STATE_BITS = LLC_STATE_BITS,
    parameter int OWNER_BITS = LLC_OWNER_BITS,
    parameter int LINE_BITS  = LLC_LINE_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_ovr,
    input  logic                  capture,
    input  logic                  fwd,
    input  logic [TAG_BITS-1:0]   mem_tag,
    input  logic [STATE_BITS-1:0] mem_state,
    input  logic [OWNER_BITS-1:0] mem_owner,
    input  logic [LINE_BITS-1:0]  mem_line,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [STATE_BITS-1:0] wr_state,
    input  logic [OWNER_BITS-1:0] wr_owner,
    input  logic [LINE_BITS-1:0]  wr_line,
    output logic [TAG_BITS-1:0]   tag_q,
    output logic [STATE_BITS-1:0] state_q,
    output logic [OWNER_BITS-1:0] owner_q,
    output logic [LINE_BITS-1:0]  line_q
);

    // Once a write has been forwarded, the SRAM read data for this way is stale
    logic ovr;

    // Forwarded write has priority; capture only loads ways not already overridden
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            state_q <= '0;
            owner_q <= '0;
            line_q  <= '0;
            ovr     <= 1'b0;
        end else if (fwd) begin
            tag_q   <= wr_tag;
            state_q <= wr_state;
            owner_q <= wr_owner;
            line_q  <= wr_line;
            ovr     <= 1'b1;
        end else begin
            if (capture && !ovr) begin
                tag_q   <= mem_tag;
                state_q <= mem_state;
                owner_q <= mem_owner;
                line_q  <= mem_line;
            end
            if (clr_ovr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/llc_set_fetch.sv
// rtl/llc_set_fetch.sv - reads all ways of a set into held buffers and triggers the lookup stage
module llc_set_fetch
    import llc_set_fetch_pkg::*;
#(
    parameter int WAYS       = LLC_WAYS,
    parameter int SET_BITS   = LLC_SET_BITS,
    parameter int TAG_BITS   = LLC_TAG_BITS,
    parameter int STATE_BITS = LLC_STATE_BITS,
    parameter int OWNER_BITS = LLC_OWNER_BITS,
    parameter int LINE_BITS  = LLC_LINE_BITS,
    parameter int RD_LATENCY = 2,
    localparam int WAY_BITS  = $clog2(WAYS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [SET_BITS-1:0]              req_set,
    input  logic [TAG_BITS-1:0]              req_tag,
    output logic                             mem_rd_en,
    output logic [SET_BITS-1:0]              mem_rd_set,
    input  logic [WAYS-1:0][TAG_BITS-1:0]    mem_tags_q,
    input  logic [WAYS-1:0][STATE_BITS-1:0]  mem_states_q,
    input  logic [WAYS-1:0][OWNER_BITS-1:0]  mem_owners_q,
    input  logic [WAYS-1:0][LINE_BITS-1:0]   mem_lines_q,
    input  logic [WAY_BITS-1:0]              mem_evict_way_q,
    input  logic                             wr_en,
    input  logic [SET_BITS-1:0]              wr_set,
    input  logic [WAY_BITS-1:0]              wr_way,
    input  logic [TAG_BITS-1:0]              wr_tag,
    input  logic [STATE_BITS-1:0]            wr_state,
    input  logic [OWNER_BITS-1:0]            wr_owner,
    input  logic [LINE_BITS-1:0]             wr_line,
    output logic [WAYS-1:0][TAG_BITS-1:0]    tags_buf,
    output logic [WAYS-1:0][STATE_BITS-1:0]  states_buf,
    output logic [WAYS-1:0][OWNER_BITS-1:0]  owners_buf,
    output logic [WAYS-1:0][LINE_BITS-1:0]   lines_buf,
    output logic [WAY_BITS-1:0]              evict_way_buf,
    output logic [TAG_BITS-1:0]              br_tag,
    output logic [SET_BITS-1:0]              br_set,
    output logic                             lookup_en,
    output logic                             lookup_mode,
    output logic                             buf_valid,
    input  logic                             buf_release
);

    localparam int CNT_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    fetch_state_t        state;
    logic [CNT_BITS-1:0] cnt;
    logic                accept;
    logic                capture;
    logic                fwd_act;

    // Requests are taken only in IDLE and never while reset is held
    assign req_ready   = (state == FETCH_IDLE) && !rst;
    assign accept      = req_ready && req_valid;
    assign mem_rd_en   = accept;
    assign mem_rd_set  = req_set;
    assign lookup_mode = LLC_LOOKUP;
    assign capture     = (state == FETCH_CAPTURE);

    // The SRAM is write-first, so a write during acceptance is already in the read data
    assign fwd_act = (state != FETCH_IDLE) && wr_en && (wr_set == br_set);

    // Fetch sequencer: read, capture after RD_LATENCY cycles, hold until released
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH_IDLE;
            cnt           <= '0;
            br_set        <= '0;
            br_tag        <= '0;
            evict_way_buf <= '0;
            lookup_en     <= 1'b0;
            buf_valid     <= 1'b0;
        end else begin
            lookup_en <= 1'b0;
            unique case (state)
                FETCH_IDLE: begin
                    if (req_valid) begin
                        br_set <= req_set;
                        br_tag <= req_tag;
                        cnt    <= CNT_BITS'(RD_LATENCY - 1);
                        state  <= (RD_LATENCY == 1) ? FETCH_CAPTURE : FETCH_READ;
                    end
                end
                FETCH_READ: begin
                    cnt <= cnt - CNT_BITS'(1);
                    if (cnt == CNT_BITS'(1)) begin
                        state <= FETCH_CAPTURE;
                    end
                end
                FETCH_CAPTURE: begin
                    evict_way_buf <= mem_evict_way_q;
                    lookup_en     <= 1'b1;
                    buf_valid     <= 1'b1;
                    state         <= FETCH_HOLD;
                end
                FETCH_HOLD: begin
                    if (buf_release) begin
                        buf_valid <= 1'b0;
                        state     <= FETCH_IDLE;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        llc_way_buf #(
            .TAG_BITS   (TAG_BITS),
            .STATE_BITS (STATE_BITS),
            .OWNER_BITS (OWNER_BITS),
            .LINE_BITS  (LINE_BITS)
        ) u_way_buf (
            .clk       (clk),
            .rst       (rst),
            .clr_ovr   (accept),
            .capture   (capture),
            .fwd       (fwd_act && (wr_way == WAY_BITS'(w))),
            .mem_tag   (mem_tags_q[w]),
            .mem_state (mem_states_q[w]),
            .mem_owner (mem_owners_q[w]),
            .mem_line  (mem_lines_q[w]),
            .wr_tag    (wr_tag),
            .wr_state  (wr_state),
            .wr_owner  (wr_owner),
            .wr_line   (wr_line),
            .tag_q     (tags_buf[w]),
            .state_q   (states_buf[w]),
            .owner_q   (owners_buf[w]),
            .line_q    (lines_buf[w])
        );
    end

endmodule

// File: tb/tb_llc_set_fetch.sv
// tb/tb_llc_set_fetch.sv - scoreboard bench for llc_set_fetch
module tb_llc_set_fetch;
    import llc_set_fetch_pkg::*;

    localparam int W   = LLC_WAYS;
    localparam int RDL = 2;

    typedef struct packed {
        llc_set_t              set;
        llc_tag_t              tag;
        logic [W-1:0][14:0]    tags;
        logic [W-1:0][2:0]     states;
        logic [W-1:0][3:0]     owners;
        logic [W-1:0][127:0]   lines;
        llc_way_t              evict;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                     req_valid, req_ready;
    llc_set_t                 req_set, mem_rd_set, wr_set, br_set;
    llc_tag_t                 req_tag, wr_tag, br_tag;
    logic                     mem_rd_en;
    logic [W-1:0][14:0]       mem_tags_q, tags_buf;
    logic [W-1:0][2:0]        mem_states_q, states_buf;
    logic [W-1:0][3:0]        mem_owners_q, owners_buf;
    logic [W-1:0][127:0]      mem_lines_q, lines_buf;
    llc_way_t                 mem_evict_way_q, wr_way, evict_way_buf;
    logic                     wr_en;
    llc_state_t               wr_state;
    owner_t                   wr_owner;
    line_t                    wr_line;
    logic                     lookup_en, lookup_mode, buf_valid, buf_release;

    llc_set_fetch #(.RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
        .mem_rd_en(mem_rd_en), .mem_rd_set(mem_rd_set),
        .mem_tags_q(mem_tags_q), .mem_states_q(mem_states_q), .mem_owners_q(mem_owners_q),
        .mem_lines_q(mem_lines_q), .mem_evict_way_q(mem_evict_way_q),
        .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag),
        .wr_state(wr_state), .wr_owner(wr_owner), .wr_line(wr_line),
        .tags_buf(tags_buf), .states_buf(states_buf), .owners_buf(owners_buf),
        .lines_buf(lines_buf), .evict_way_buf(evict_way_buf),
        .br_tag(br_tag), .br_set(br_set),
        .lookup_en(lookup_en), .lookup_mode(lookup_mode), .buf_valid(buf_valid),
        .buf_release(buf_release)
    );

    int n_cmp = 0;
    int n_err = 0;
    int lookup_cnt = 0;
    exp_t sb_q[$];
    exp_t cur;

    // SRAM contents model
    function automatic llc_tag_t m_tag(input int s, input int w);
        if (s == 5 && w == 3) return llc_tag_t'(15'h12);
        if (s == 5 && w == 2) return llc_tag_t'(15'h11);
        return llc_tag_t'((s << 5) ^ (w * 37) ^ 'h155);
    endfunction

    function automatic llc_state_t m_state(input int w);
        return llc_state_t'((w % 7) + 1);
    endfunction

    function automatic owner_t m_owner(input int s, input int w);
        return owner_t'(s ^ w ^ 9);
    endfunction

    function automatic line_t m_line(input int s, input int w);
        return {32'(s), 32'(w), 32'hC0DE0000 + 32'(w), 32'(s * w)};
    endfunction

    function automatic llc_way_t m_evict(input int s);
        return llc_way_t'(s + 3);
    endfunction

    function automatic exp_t mk(input int s, input llc_tag_t t);
        exp_t e;
        e = '0;
        e.set = llc_set_t'(s);
        e.tag = t;
        for (int w = 0; w < W; w++) begin
            e.tags[w]   = m_tag(s, w);
            e.states[w] = m_state(w);
            e.owners[w] = m_owner(s, w);
            e.lines[w]  = m_line(s, w);
        end
        e.evict = m_evict(s);
        return e;
    endfunction

    function automatic exp_t apply(input exp_t e, input int way, input llc_tag_t t,
                                   input llc_state_t st, input owner_t o, input line_t l);
        exp_t r;
        r = e;
        r.tags[way]   = t;
        r.states[way] = st;
        r.owners[way] = o;
        r.lines[way]  = l;
        return r;
    endfunction

    // SRAM read pipeline: q valid RDL cycles after the read strobe, junk otherwise
    logic [RDL-1:0] pv = '0;
    llc_set_t       ps [RDL];
    always @(posedge clk) begin
        pv[0] <= mem_rd_en;
        ps[0] <= mem_rd_set;
        for (int i = 1; i < RDL; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
        end
    end

    always_comb begin
        for (int w = 0; w < W; w++) begin
            if (pv[RDL-1]) begin
                mem_tags_q[w]   = m_tag(int'(ps[RDL-1]), w);
                mem_states_q[w] = m_state(w);
                mem_owners_q[w] = m_owner(int'(ps[RDL-1]), w);
                mem_lines_q[w]  = m_line(int'(ps[RDL-1]), w);
            end else begin
                mem_tags_q[w]   = '1;
                mem_states_q[w] = '1;
                mem_owners_q[w] = '1;
                mem_lines_q[w]  = '1;
            end
        end
        mem_evict_way_q = pv[RDL-1] ? m_evict(int'(ps[RDL-1])) : '1;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_bufs(input string tag, input exp_t e);
        check_eq({tag, ".tags"},   256'(tags_buf),      256'(e.tags));
        check_eq({tag, ".states"}, 256'(states_buf),    256'(e.states));
        check_eq({tag, ".owners"}, 256'(owners_buf),    256'(e.owners));
        check_eq({tag, ".evict"},  256'(evict_way_buf), 256'(e.evict));
        check_eq({tag, ".br_set"}, 256'(br_set),        256'(e.set));
        check_eq({tag, ".br_tag"}, 256'(br_tag),        256'(e.tag));
        for (int w = 0; w < W; w++) begin
            check_eq($sformatf("%s.lines[%0d]", tag, w), 256'(lines_buf[w]), 256'(e.lines[w]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input int s, input int way, input llc_tag_t t,
                            input llc_state_t st, input owner_t o, input line_t l);
        wr_en    = 1'b1;
        wr_set   = llc_set_t'(s);
        wr_way   = llc_way_t'(way);
        wr_tag   = t;
        wr_state = st;
        wr_owner = o;
        wr_line  = l;
    endtask

    // Scoreboard consumer: each lookup pulse pops one expected set image
    always @(negedge clk) begin
        if (!rst && lookup_en === 1'b1) begin
            lookup_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("lookup_with_empty_sb", 256'(sb_q.size()), 256'(1));
            end else begin
                cmp_bufs("lookup", sb_q.pop_front());
                check_eq("lookup.buf_valid", 256'(buf_valid), 256'(1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        req_valid = 1'b0; req_set = '0; req_tag = '0;
        wr_en = 1'b0; wr_set = '0; wr_way = '0; wr_tag = '0;
        wr_state = '0; wr_owner = '0; wr_line = '0;
        buf_release = 1'b0;

        // Reset: requests are not acknowledged while rst is held
        rst = 1'b1;
        req_valid = 1'b1;
        repeat (3) tick();
        check_eq("ready_in_reset", 256'(req_ready), 256'(0));
        check_eq("rd_en_in_reset", 256'(mem_rd_en), 256'(0));
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("ready_after_reset", 256'(req_ready), 256'(1));
        check_eq("buf_valid_reset", 256'(buf_valid), 256'(0));
        check_eq("lookup_en_reset", 256'(lookup_en), 256'(0));
        check_eq("lookup_mode", 256'(lookup_mode), 256'(LLC_LOOKUP));
        cmp_bufs("reset", exp_t'(0));

        // T0: accept set 0x05, read strobe in the same cycle
        tick();
        req_valid = 1'b1; req_set = 9'h005; req_tag = 15'h1234;
        #1;
        check_eq("t0_rd_en", 256'(mem_rd_en), 256'(1));
        check_eq("t0_rd_set", 256'(mem_rd_set), 256'(9'h005));
        cur = mk(5, 15'h1234);
        sb_q.push_back(cur);

        // T1 (READ): forward state=LLC_I into way 7
        tick();
        req_valid = 1'b0;
        check_eq("t1_ready", 256'(req_ready), 256'(0));
        check_eq("t1_lookup_en", 256'(lookup_en), 256'(0));
        drive_wr(5, 7, 15'h0707, LLC_I, 4'h0, {4{32'hAAAA5555}});
        cur = apply(cur, 7, 15'h0707, LLC_I, 4'h0, {4{32'hAAAA5555}});
        sb_q[sb_q.size()-1] = cur;

        // T2 (CAPTURE): forwarded tag 0x3A must beat the SRAM tag 0x11 in way 2
        tick();
        check_eq("t2_lookup_en", 256'(lookup_en), 256'(0));
        check_eq("t2_buf_valid", 256'(buf_valid), 256'(0));
        drive_wr(5, 2, 15'h003A, 3'd5, 4'h3, {4{32'hBBBB0000}});
        cur = apply(cur, 2, 15'h003A, 3'd5, 4'h3, {4{32'hBBBB0000}});
        sb_q[sb_q.size()-1] = cur;

        // T3: lookup pulse with captured set
        tick();
        wr_en = 1'b0;
        check_eq("t3_lookup_en", 256'(lookup_en), 256'(1));
        check_eq("t3_buf_valid", 256'(buf_valid), 256'(1));
        check_eq("t3_tag_way3", 256'(tags_buf[3]), 256'(15'h12));
        check_eq("t3_state_way7", 256'(states_buf[7]), 256'(LLC_I));
        check_eq("t3_tag_way2", 256'(tags_buf[2]), 256'(15'h3A));

        // HOLD: write to another set is ignored
        tick();
        check_eq("t4_lookup_en", 256'(lookup_en), 256'(0));
        drive_wr(6, 0, 15'h7EEE, 3'd6, 4'hF, {4{32'hDEADBEEF}});
        tick();
        cmp_bufs("hold_other_set", cur);
        drive_wr(5, 0, 15'h0100, 3'd2, 4'b1010, {4{32'hCCCC1111}});
        cur = apply(cur, 0, 15'h0100, 3'd2, 4'b1010, {4{32'hCCCC1111}});
        tick();
        wr_en = 1'b0;
        check_eq("hold_owner_way0", 256'(owners_buf[0]), 256'(4'b1010));
        check_eq("hold_no_relookup", 256'(lookup_en), 256'(0));
        check_eq("hold_buf_valid", 256'(buf_valid), 256'(1));
        cmp_bufs("hold_fwd", cur);

        // Second request held through HOLD, accepted only after release
        req_valid = 1'b1; req_set = 9'h00A; req_tag = 15'h2BCD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_ready", 256'(req_ready), 256'(0));
            check_eq("hold_rd_en", 256'(mem_rd_en), 256'(0));
        end
        buf_release = 1'b1;
        tick();
        buf_release = 1'b0;
        #1;
        check_eq("rel_ready", 256'(req_ready), 256'(1));
        check_eq("rel_rd_en", 256'(mem_rd_en), 256'(1));
        check_eq("rel_rd_set", 256'(mem_rd_set), 256'(9'h00A));
        check_eq("rel_buf_valid", 256'(buf_valid), 256'(0));
        cur = mk(10, 15'h2BCD);
        sb_q.push_back(cur);
        tick();
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (lookup_en === 1'b1) got = 1;
        end
        check_eq("second_lookup_seen", 256'(got), 256'(1));
        repeat (3) tick();
        check_eq("lookup_count", 256'(lookup_cnt), 256'(2));
        check_eq("sb_drained", 256'(sb_q.size()), 256'(0));

        // Reset during READ aborts the fetch
        buf_release = 1'b1;
        tick();
        buf_release = 1'b0;
        tick();
        req_valid = 1'b1; req_set = 9'h00C; req_tag = 15'h0333;
        #1;
        check_eq("abort_accept", 256'(mem_rd_en), 256'(1));
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("abort_ready", 256'(req_ready), 256'(1));
        check_eq("abort_buf_valid", 256'(buf_valid), 256'(0));
        check_eq("abort_lookup_en", 256'(lookup_en), 256'(0));
        cmp_bufs("abort", exp_t'(0));
        repeat (5) tick();
        check_eq("abort_no_lookup", 256'(lookup_cnt), 256'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/llc_set_fetch.md
Name: llc_set_fetch

Overview:
Upstream stage of the LLC lookup block. It accepts one request (set, tag) at a time, reads every way of that set from the per-way tag/state/owner/line SRAM banks and the per-set evict-way memory, and captures the data into set buffers. It then pulses lookup_en so the lookup stage computes hit, empty-way and owned-mask results. The buffers stay held and coherent with update-stage writes until downstream releases them.

Parameters:
WAYS, 16, associativity; WAY_BITS = $clog2(WAYS)
SET_BITS, 9, set index width
TAG_BITS, 15, tag width
STATE_BITS, 3, llc_state_t width
OWNER_BITS, 4, owned-word mask width (one bit per word)
LINE_BITS, 128, line data width
RD_LATENCY, 2, SRAM read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  new request present
req_ready  out  1  block can accept; high only in IDLE
req_set  in  SET_BITS  request set index
req_tag  in  TAG_BITS  request tag
mem_rd_en  out  1  read strobe to all way banks and the evict memory
mem_rd_set  out  SET_BITS  read address
mem_tags_q  in  WAYS x TAG_BITS  read data
mem_states_q  in  WAYS x STATE_BITS  read data
mem_owners_q  in  WAYS x OWNER_BITS  read data
mem_lines_q  in  WAYS x LINE_BITS  read data
mem_evict_way_q  in  WAY_BITS  per-set replacement pointer
wr_en  in  1  update-stage write to the SRAMs this cycle
wr_set  in  SET_BITS  write set
wr_way  in  WAY_BITS  write way
wr_tag, wr_state, wr_owner, wr_line  in  field widths  written values
tags_buf, states_buf, owners_buf, lines_buf  out  WAYS x field  set buffers
evict_way_buf  out  WAY_BITS  captured replacement pointer
br_tag  out  TAG_BITS  held request tag (line_br.tag)
br_set  out  SET_BITS  held request set
lookup_en  out  1  one-cycle pulse: buffers valid, lookup may run
lookup_mode  out  1  constant LLC_LOOKUP
buf_valid  out  1  buffers hold a live set
release  in  1  downstream finished with the set

Behaviour:
- Reset (sync, rst=1): state=IDLE; all buffers, br_*, evict_way_buf, override mask = 0; lookup_en=0; buf_valid=0; mem_rd_en=0; req_ready=0 during reset, 1 in the first cycle after it.
- FSM IDLE -> READ -> CAPTURE -> HOLD -> IDLE.
- IDLE: req_ready=1. On req_valid: latch br_set/br_tag, drive mem_rd_en=1 and mem_rd_set=req_set combinationally in the same cycle, clear override mask, load cnt=RD_LATENCY-1, go to READ. If RD_LATENCY=1, go directly to CAPTURE.
- READ: decrement cnt. At cnt=1 go to CAPTURE, so the memory q is sampled exactly RD_LATENCY cycles after mem_rd_en.
- CAPTURE: for each way w, buf[w] <= override[w] ? buf[w] : mem_q[w]; evict_way_buf <= mem_evict_way_q. Next cycle: lookup_en=1 for exactly one cycle, buf_valid=1, state=HOLD.
- HOLD: buf_valid=1. On release go to IDLE and clear buf_valid next cycle. A new request is accepted no earlier than the cycle after release.
- Write forwarding (READ, CAPTURE, HOLD): when wr_en && wr_set==br_set, write all four fields of way wr_way into its buffers and set override[wr_way]. If this coincides with CAPTURE, the forwarded write wins over mem_q for that way. A later write to the same way overwrites an earlier one. Writes to other sets are ignored. Writes in HOLD do not re-pulse lookup_en.
- Write in the same cycle as request acceptance (IDLE): not forwarded, because the SRAM is write-first and the read sees it.
- release outside HOLD is ignored. req_valid outside IDLE is not acknowledged; the requester holds it.
- rst mid-operation aborts: buffers zeroed, no lookup_en pulse.

Decomposition:
- Shared package: llc_tag_t, llc_state_t, owner_t, line_t, llc_way_t, llc_set_t, LLC_I, LLC_LOOKUP, and the fetch FSM enum.
- Sub-module llc_way_buf: a single-way register slice (capture/forward mux, override bit), generated WAYS times.

Test Plan:
1. RD_LATENCY=2, req set 0x05 with mem_tags_q[3]=0x12 -> mem_rd_en at T0, capture at T2, lookup_en high only at T3, tags_buf[3]=0x12, buf_valid=1.
2. Write way 7 of set 0x05 with state=LLC_I at T1 (READ) while mem returns a valid state -> states_buf[7]=LLC_I after capture.
3. Write at the CAPTURE cycle to way 2 with tag 0x3A versus mem tag 0x11 -> tags_buf[2]=0x3A.
4. In HOLD, wr_set=0x06 (other set) -> buffers unchanged. Then wr_set=0x05, way 0, owner=4'b1010 -> owners_buf[0]=4'b1010, and lookup_en stays 0.
5. req_valid held through HOLD; release at Tn -> req_ready=1 at Tn+1, second request accepted at Tn+1, and only one lookup_en pulse per request.
6. Assert rst during READ -> next cycle: IDLE, buf_valid=0, all buffers 0, no lookup_en pulse.
